// File: rtl/uart_cmd_ctrl_if.sv
// uart_cmd_ctrl_if
// Bundles every non-clock/reset signal of the command controller.
//   master : controller side (drives register-file, ALU and TX FIFO controls)
//   slave  : environment side (UART RX, register file, ALU, TX FIFO)
// Signals:
//   rx_p_data/rx_d_vld   received byte and its one-cycle strobe
//   rddata/rddata_vld    register-file read return
//   alu_out/out_vld      ALU result return
//   fifo_full            TX FIFO back-pressure
//   address/wr_data/wr_en/rd_en   register-file access
//   alu_fun/alu_en/clk_en        ALU control and clock-gate enable
//   tx_p_data/tx_d_vld           byte pushed to the TX FIFO
//   clk_div_en/busy/err_pulse    status
interface uart_cmd_ctrl_if #(
  parameter int FRAME_W = 8,
  parameter int ALU_W   = 16,
  parameter int FUN_W   = 4,
  parameter int ADDR_W  = 4
);
  logic [FRAME_W-1:0] rx_p_data;
  logic               rx_d_vld;
  logic [FRAME_W-1:0] rddata;
  logic               rddata_vld;
  logic [ALU_W-1:0]   alu_out;
  logic               out_vld;
  logic               fifo_full;
  logic [ADDR_W-1:0]  address;
  logic [FRAME_W-1:0] wr_data;
  logic               wr_en;
  logic               rd_en;
  logic [FUN_W-1:0]   alu_fun;
  logic               alu_en;
  logic               clk_en;
  logic [FRAME_W-1:0] tx_p_data;
  logic               tx_d_vld;
  logic               clk_div_en;
  logic               busy;
  logic               err_pulse;

  modport master (
    input  rx_p_data, rx_d_vld, rddata, rddata_vld, alu_out, out_vld, fifo_full,
    output address, wr_data, wr_en, rd_en, alu_fun, alu_en, clk_en,
           tx_p_data, tx_d_vld, clk_div_en, busy, err_pulse
  );

  modport slave (
    output rx_p_data, rx_d_vld, rddata, rddata_vld, alu_out, out_vld, fifo_full,
    input  address, wr_data, wr_en, rd_en, alu_fun, alu_en, clk_en,
           tx_p_data, tx_d_vld, clk_div_en, busy, err_pulse
  );
endinterface

// File: rtl/uart_cmd_ctrl.sv
// uart_cmd_ctrl
// Parses UART command frames into register-file writes/reads and ALU runs,
// and serialises results (LSB byte first) into the TX FIFO.
// Ports:
//   clk  system clock
//   rst  synchronous active-low reset
//   bus  uart_cmd_ctrl_if.master, all data/control signals
//
// state    | meaning
// ---------+-------------------------------------------------
// IDLE     | waiting for an opcode byte
// GET_ADDR | AA/BB: waiting for the register address
// GET_DATA | AA: waiting for the write data
// GET_OPA  | CC: waiting for operand A (written to reg 0)
// GET_OPB  | CC: waiting for operand B (written to reg 1)
// GET_FUN  | CC/DD: waiting for the ALU function byte
// WAIT_RD  | waiting for register read data
// WAIT_ALU | waiting for the ALU result
// SEND     | pushing the result bytes to the TX FIFO
module uart_cmd_ctrl #(
  parameter int FRAME_W = 8,
  parameter int ALU_W   = 16,
  parameter int FUN_W   = 4,
  parameter int ADDR_W  = 4,
  parameter int TIMEOUT = 1023
) (
  input  logic            clk,
  input  logic            rst,
  uart_cmd_ctrl_if.master bus
);
  localparam int NBYTES = ALU_W / FRAME_W;
  localparam int CNT_W  = $clog2(NBYTES + 1);
  localparam int TO_W   = $clog2(TIMEOUT);

  localparam logic [FRAME_W-1:0] OP_WR   = FRAME_W'(8'hAA);
  localparam logic [FRAME_W-1:0] OP_RD   = FRAME_W'(8'hBB);
  localparam logic [FRAME_W-1:0] OP_ALU  = FRAME_W'(8'hCC);
  localparam logic [FRAME_W-1:0] OP_ALUN = FRAME_W'(8'hDD);
  localparam logic [FRAME_W-1:0] OP_STAT = FRAME_W'(8'hEE);

  typedef enum logic [3:0] {
    IDLE, GET_ADDR, GET_DATA, GET_OPA, GET_OPB, GET_FUN, WAIT_RD, WAIT_ALU, SEND
  } state_t;

  state_t             state_q, state_d;
  logic               rd_cmd_q, rd_cmd_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [FRAME_W-1:0] wr_data_q, wr_data_d;
  logic               wr_en_q, wr_en_d, rd_en_q, rd_en_d;
  logic [FUN_W-1:0]   fun_q, fun_d;
  logic               alu_en_q, alu_en_d, clk_en_q, clk_en_d;
  logic [FRAME_W-1:0] tx_data_q, tx_data_d;
  logic               tx_vld_q, tx_vld_d;
  logic               div_en_q, busy_q, busy_d, err_q, err_d;
  logic [FRAME_W-1:0] err_cnt_q, err_cnt_d;
  logic [TO_W-1:0]    to_q, to_d;
  logic [ALU_W-1:0]   buf_q, buf_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               inc_err, clr_err, accepted, waiting;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      rd_cmd_q  <= 1'b0;
      addr_q    <= '0;
      wr_data_q <= '0;
      wr_en_q   <= 1'b0;
      rd_en_q   <= 1'b0;
      fun_q     <= '0;
      alu_en_q  <= 1'b0;
      clk_en_q  <= 1'b0;
      tx_data_q <= '0;
      tx_vld_q  <= 1'b0;
      div_en_q  <= 1'b0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
      to_q      <= '0;
      buf_q     <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      rd_cmd_q  <= rd_cmd_d;
      addr_q    <= addr_d;
      wr_data_q <= wr_data_d;
      wr_en_q   <= wr_en_d;
      rd_en_q   <= rd_en_d;
      fun_q     <= fun_d;
      alu_en_q  <= alu_en_d;
      clk_en_q  <= clk_en_d;
      tx_data_q <= tx_data_d;
      tx_vld_q  <= tx_vld_d;
      div_en_q  <= 1'b1;
      busy_q    <= busy_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
      to_q      <= to_d;
      buf_q     <= buf_d;
      cnt_q     <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    rd_cmd_d  = rd_cmd_q;
    addr_d    = addr_q;
    wr_data_d = wr_data_q;
    wr_en_d   = 1'b0;
    rd_en_d   = 1'b0;
    fun_d     = fun_q;
    alu_en_d  = 1'b0;
    tx_data_d = tx_data_q;
    tx_vld_d  = 1'b0;
    buf_d     = buf_q;
    cnt_d     = cnt_q;
    inc_err   = 1'b0;
    clr_err   = 1'b0;
    accepted  = 1'b0;
    waiting   = (state_q != IDLE) && (state_q != SEND);

    case (state_q)
      IDLE: if (bus.rx_d_vld) begin
        case (bus.rx_p_data)
          OP_WR:   begin rd_cmd_d = 1'b0; state_d = GET_ADDR; end
          OP_RD:   begin rd_cmd_d = 1'b1; state_d = GET_ADDR; end
          OP_ALU:  state_d = GET_OPA;
          OP_ALUN: state_d = GET_FUN;
          OP_STAT: begin
            buf_d   = ALU_W'(err_cnt_q);
            cnt_d   = CNT_W'(1);
            clr_err = 1'b1;
            state_d = SEND;
          end
          default: inc_err = 1'b1;
        endcase
      end
      GET_ADDR: if (bus.rx_d_vld) begin
        accepted = 1'b1;
        addr_d   = bus.rx_p_data[ADDR_W-1:0];
        if (rd_cmd_q) begin
          rd_en_d = 1'b1;
          state_d = WAIT_RD;
        end else begin
          state_d = GET_DATA;
        end
      end
      GET_DATA: if (bus.rx_d_vld) begin
        accepted  = 1'b1;
        wr_data_d = bus.rx_p_data;
        wr_en_d   = 1'b1;
        state_d   = IDLE;
      end
      GET_OPA: if (bus.rx_d_vld) begin
        accepted  = 1'b1;
        addr_d    = ADDR_W'(0);
        wr_data_d = bus.rx_p_data;
        wr_en_d   = 1'b1;
        state_d   = GET_OPB;
      end
      GET_OPB: if (bus.rx_d_vld) begin
        accepted  = 1'b1;
        addr_d    = ADDR_W'(1);
        wr_data_d = bus.rx_p_data;
        wr_en_d   = 1'b1;
        state_d   = GET_FUN;
      end
      GET_FUN: if (bus.rx_d_vld) begin
        accepted = 1'b1;
        fun_d    = bus.rx_p_data[FUN_W-1:0];
        alu_en_d = 1'b1;
        state_d  = WAIT_ALU;
      end
      WAIT_RD: begin
        inc_err = bus.rx_d_vld;
        if (bus.rddata_vld) begin
          accepted = 1'b1;
          buf_d    = ALU_W'(bus.rddata);
          cnt_d    = CNT_W'(1);
          state_d  = SEND;
        end
      end
      WAIT_ALU: begin
        inc_err = bus.rx_d_vld;
        if (bus.out_vld) begin
          accepted = 1'b1;
          buf_d    = bus.alu_out;
          cnt_d    = CNT_W'(NBYTES);
          state_d  = SEND;
        end
      end
      SEND: begin
        inc_err = bus.rx_d_vld;
        if (!bus.fifo_full) begin
          tx_data_d = buf_q[FRAME_W-1:0];
          tx_vld_d  = 1'b1;
          buf_d     = buf_q >> FRAME_W;
          cnt_d     = cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Idle-cycle watchdog; an abort never coincides with an accepted
    // byte, so no strobe has been scheduled when it fires.
    to_d = '0;
    if (waiting && !accepted) begin
      if (to_q == TO_W'(TIMEOUT - 1)) begin
        state_d = IDLE;
        inc_err = 1'b1;
      end else begin
        to_d = to_q + 1'b1;
      end
    end

    err_d = inc_err;
    if (clr_err)
      err_cnt_d = '0;
    else if (inc_err && (err_cnt_q != '1))
      err_cnt_d = err_cnt_q + 1'b1;
    else
      err_cnt_d = err_cnt_q;

    clk_en_d = (state_d == GET_FUN) || (state_d == WAIT_ALU);
    busy_d   = (state_d != IDLE);
  end

  assign bus.address    = addr_q;
  assign bus.wr_data    = wr_data_q;
  assign bus.wr_en      = wr_en_q;
  assign bus.rd_en      = rd_en_q;
  assign bus.alu_fun    = fun_q;
  assign bus.alu_en     = alu_en_q;
  assign bus.clk_en     = clk_en_q;
  assign bus.tx_p_data  = tx_data_q;
  assign bus.tx_d_vld   = tx_vld_q;
  assign bus.clk_div_en = div_en_q;
  assign bus.busy       = busy_q;
  assign bus.err_pulse  = err_q;
endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// tb_uart_cmd_ctrl
// Directed bench for uart_cmd_ctrl with scoreboards for TX bytes and
// register writes; other strobes are counted by a negedge monitor.
module tb_uart_cmd_ctrl;
  localparam int FW = 8;
  localparam int AW = 16;
  localparam int UW = 4;
  localparam int DW = 4;
  localparam int TO = 20;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  uart_cmd_ctrl_if #(.FRAME_W(FW), .ALU_W(AW), .FUN_W(UW), .ADDR_W(DW)) bus ();

  uart_cmd_ctrl #(.FRAME_W(FW), .ALU_W(AW), .FUN_W(UW), .ADDR_W(DW), .TIMEOUT(TO))
    dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int errors = 0;
  logic [7:0]  sb_tx[$];
  logic [11:0] sb_wr[$];
  int tx_cnt = 0, wr_cnt = 0, rd_cnt = 0, alu_cnt = 0, err_cnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus.tx_d_vld) begin
      tx_cnt++;
      if (sb_tx.size() == 0) check("tx_unexpected", {24'h0, bus.tx_p_data}, 32'hFFFF_FFFF);
      else check("tx_byte", {24'h0, bus.tx_p_data}, {24'h0, sb_tx.pop_front()});
    end
    if (bus.wr_en) begin
      wr_cnt++;
      if (sb_wr.size() == 0) check("wr_unexpected", {20'h0, bus.address, bus.wr_data}, 32'hFFFF_FFFF);
      else check("wr_addr_data", {20'h0, bus.address, bus.wr_data}, {20'h0, sb_wr.pop_front()});
    end
    if (bus.rd_en)     rd_cnt++;
    if (bus.alu_en)    alu_cnt++;
    if (bus.err_pulse) err_cnt++;
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    bus.rx_p_data = b;
    bus.rx_d_vld  = 1'b1;
    @(negedge clk);
    bus.rx_d_vld  = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic wait_tx_empty(input string tag);
    int n = 0;
    while (sb_tx.size() != 0 && n < 40) begin @(negedge clk); #1; n++; end
    check(tag, sb_tx.size(), 0);
  endtask

  initial begin
    int n, c0, c1;
    logic [7:0] b;
    bus.rx_p_data = '0; bus.rx_d_vld = 1'b0; bus.rddata = '0; bus.rddata_vld = 1'b0;
    bus.alu_out = '0; bus.out_vld = 1'b0; bus.fifo_full = 1'b0;

    // reset state
    idle_cycles(3);
    check("rst_busy", bus.busy, 0);
    check("rst_clk_div_en", bus.clk_div_en, 0);
    check("rst_tx_vld", bus.tx_d_vld, 0);
    check("rst_address", bus.address, 0);
    rst = 1'b1;
    idle_cycles(2);
    check("clk_div_en_on", bus.clk_div_en, 1);
    check("idle_busy", bus.busy, 0);

    // register write
    sb_wr.push_back({4'h5, 8'h3C});
    send_byte(8'hAA); send_byte(8'h05);
    check("busy_in_frame", bus.busy, 1);
    send_byte(8'h3C);
    idle_cycles(2);
    check("wr_count", wr_cnt, 1);
    check("wr_busy_done", bus.busy, 0);

    // register read, data returned 3 cycles after rd_en
    sb_tx.push_back(8'h7E);
    send_byte(8'hBB); send_byte(8'h02);
    n = 0;
    while (rd_cnt == 0 && n < 10) begin @(negedge clk); #1; n++; end
    check("rd_en_seen", rd_cnt, 1);
    check("rd_address", bus.address, 2);
    repeat (2) @(negedge clk);
    bus.rddata = 8'h7E; bus.rddata_vld = 1'b1;
    @(negedge clk);
    bus.rddata_vld = 1'b0;
    wait_tx_empty("rd_tx_done");

    // ALU with operands, back-pressure between result bytes
    sb_wr.push_back({4'h0, 8'h11});
    sb_wr.push_back({4'h1, 8'h22});
    sb_tx.push_back(8'hEF); sb_tx.push_back(8'hBE);
    send_byte(8'hCC); send_byte(8'h11); send_byte(8'h22); send_byte(8'h01);
    n = 0;
    while (alu_cnt == 0 && n < 10) begin @(negedge clk); #1; n++; end
    check("alu_en_seen", alu_cnt, 1);
    check("alu_fun", bus.alu_fun, 1);
    check("clk_en_wait", bus.clk_en, 1);
    check("alu_wr_count", wr_cnt, 3);
    @(negedge clk);
    bus.alu_out = 16'hBEEF; bus.out_vld = 1'b1;
    @(negedge clk);
    bus.out_vld = 1'b0;
    c0 = tx_cnt; n = 0;
    while (tx_cnt == c0 && n < 10) begin @(negedge clk); #1; n++; end
    bus.fifo_full = 1'b1;
    c1 = tx_cnt;
    idle_cycles(4);
    check("stall_no_tx", tx_cnt, c1);
    check("stall_busy", bus.busy, 1);
    bus.fifo_full = 1'b0;
    wait_tx_empty("alu_tx_done");
    idle_cycles(1);
    check("clk_en_idle", bus.clk_en, 0);
    check("alu_tx_count", tx_cnt, 3);

    // timeout inside a write frame, then status reads
    c0 = err_cnt; c1 = wr_cnt;
    send_byte(8'hAA); send_byte(8'h03);
    n = 0;
    while (err_cnt == c0 && n < TO + 10) begin @(negedge clk); #1; n++; end
    check("timeout_err", err_cnt, c0 + 1);
    check("timeout_no_wr", wr_cnt, c1);
    idle_cycles(1);
    check("timeout_idle", bus.busy, 0);
    sb_tx.push_back(8'h01);
    send_byte(8'hEE);
    wait_tx_empty("status_one");
    sb_tx.push_back(8'h00);
    send_byte(8'hEE);
    wait_tx_empty("status_zero");

    // unknown opcodes and saturation
    c0 = err_cnt;
    send_byte(8'h55);
    idle_cycles(1);
    check("bad_op_err", err_cnt, c0 + 1);
    check("bad_op_idle", bus.busy, 0);
    for (int i = 0; i < 256; i++) begin
      do b = 8'($urandom_range(0, 255));
      while (b == 8'hAA || b == 8'hBB || b == 8'hCC || b == 8'hDD || b == 8'hEE);
      send_byte(b);
    end
    idle_cycles(1);
    check("bad_op_count", err_cnt, c0 + 257);
    sb_tx.push_back(8'hFF);
    send_byte(8'hEE);
    wait_tx_empty("status_sat");
    sb_tx.push_back(8'h00);
    send_byte(8'hEE);
    wait_tx_empty("status_cleared");

    // overrun while waiting for read data
    sb_tx.push_back(8'h5A);
    send_byte(8'hBB); send_byte(8'h04);
    c0 = err_cnt;
    send_byte(8'h99);
    idle_cycles(1);
    check("overrun_err", err_cnt, c0 + 1);
    check("overrun_busy", bus.busy, 1);
    bus.rddata = 8'h5A; bus.rddata_vld = 1'b1;
    @(negedge clk);
    bus.rddata_vld = 1'b0;
    wait_tx_empty("overrun_tx");
    sb_tx.push_back(8'h01);
    send_byte(8'hEE);
    wait_tx_empty("overrun_status");

    // reset in the middle of SEND
    sb_tx.push_back(8'h34);
    send_byte(8'hDD); send_byte(8'h07);
    n = 0; c0 = alu_cnt;
    while (alu_cnt == c0 && n < 10) begin @(negedge clk); #1; n++; end
    check("dd_alu_en", alu_cnt, c0 + 1);
    check("dd_alu_fun", bus.alu_fun, 7);
    @(negedge clk);
    bus.alu_out = 16'h1234; bus.out_vld = 1'b1;
    @(negedge clk);
    bus.out_vld = 1'b0;
    c0 = tx_cnt; n = 0;
    while (tx_cnt == c0 && n < 10) begin @(negedge clk); #1; n++; end
    rst = 1'b0;
    c1 = tx_cnt;
    idle_cycles(2);
    check("rst_mid_busy", bus.busy, 0);
    check("rst_mid_tx_data", bus.tx_p_data, 0);
    check("rst_mid_clk_en", bus.clk_en, 0);
    check("rst_mid_div", bus.clk_div_en, 0);
    rst = 1'b1;
    idle_cycles(6);
    check("rst_mid_no_tx", tx_cnt, c1);
    check("rst_mid_sb", sb_tx.size(), 0);
    check("rst_mid_idle", bus.busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/uart_cmd_ctrl.md
# uart_cmd_ctrl

Parametrised command controller between the UART receiver/transmitter, the register file, the ALU and the TX FIFO.
- Parses multi-byte command frames arriving as single-cycle `rx_d_vld` pulses and drives register-file writes/reads and ALU operations.
- Serialises results of configurable width into frame-width bytes (LSB first) toward the TX FIFO under back-pressure.
- Adds over the previous controller: frame timeout, unknown-opcode/overrun error counting, and a status-read command.

## Interface
Parameters:
- `FRAME_W`, 8: UART byte / register data width.
- `ALU_W`, 16: ALU result width; must be an integer multiple of `FRAME_W`, ≥ `FRAME_W`.
- `FUN_W`, 4: ALU function code width.
- `ADDR_W`, 4: register-file address width.
- `TIMEOUT`, 1023: idle cycles allowed inside an unfinished frame or wait (≥ 2).

Ports (one clock; reset is synchronous and active-low):
- `clk` in 1: system clock.
- `rst` in 1: synchronous active-low reset.
- `rx_p_data` in FRAME_W: received byte.
- `rx_d_vld` in 1: one-cycle strobe, `rx_p_data` valid.
- `rddata` in FRAME_W: register-file read data.
- `rddata_vld` in 1: read data valid.
- `alu_out` in ALU_W: ALU result.
- `out_vld` in 1: ALU result valid.
- `fifo_full` in 1: TX FIFO cannot accept a byte.
- `address` out ADDR_W: register-file address.
- `wr_data` out FRAME_W: register write data.
- `wr_en` out 1: one-cycle write strobe.
- `rd_en` out 1: one-cycle read strobe.
- `alu_fun` out FUN_W: ALU function.
- `alu_en` out 1: one-cycle ALU start.
- `clk_en` out 1: ALU clock-gate enable.
- `tx_p_data` out FRAME_W: byte to TX FIFO.
- `tx_d_vld` out 1: one-cycle push strobe.
- `clk_div_en` out 1: clock divider enable.
- `busy` out 1: state ≠ IDLE.
- `err_pulse` out 1: one-cycle error indication.

## Operation
- All outputs registered. Reset value: all 0, including `clk_div_en`; after reset `clk_div_en` = 1 permanently. State IDLE, error counter 0, timeout counter 0.
- Opcodes are decoded in IDLE on `rx_d_vld`:
  - 0xAA: reg write; → GET_ADDR.
  - 0xBB: reg read; → GET_ADDR.
  - 0xCC: ALU with operands; → GET_OPA.
  - 0xDD: ALU without operands; → GET_FUN.
  - 0xEE: status read; load error counter into the TX buffer (1 byte), clear counter; → SEND.
  - Other: stay IDLE, `err_pulse`, error counter increment.
- GET_ADDR, on byte:
  - Latch `address` = byte[ADDR_W-1:0].
  - AA → GET_DATA.
  - BB → `rd_en` pulse; → WAIT_RD.
- GET_DATA, on byte: `wr_data` = byte, `wr_en` pulse at latched address; → IDLE.
- GET_OPA, on byte: write to address 0; → GET_OPB.
- GET_OPB, on byte: write to address 1; → GET_FUN.
- GET_FUN, on byte: `alu_fun` = byte[FUN_W-1:0], `alu_en` pulse; → WAIT_ALU.
- `clk_en` = 1 while state ∈ {GET_FUN, WAIT_ALU}.
- WAIT_RD, on `rddata_vld`: capture `rddata`, byte count 1; → SEND.
- WAIT_ALU, on `out_vld`: capture `alu_out`, byte count ALU_W/FRAME_W; → SEND.
- SEND:
  - On each edge with `fifo_full`=0, emit the next byte, LSB byte first, with `tx_d_vld`=1 the following cycle.
  - `fifo_full`=1 stalls without loss.
  - After the last byte → IDLE.
- Timeout:
  - Counter runs in every non-IDLE, non-SEND state and clears on each accepted byte/valid.
  - Reaching TIMEOUT: → IDLE, `err_pulse`, counter increment, no strobes issued.
- Overrun: `rx_d_vld` in WAIT_RD/WAIT_ALU/SEND drops the byte, raises `err_pulse`, increments the counter, and does not change state.
- Error counter is FRAME_W wide and saturates at all-ones. Simultaneous increment and EE clear: clear wins, and the increment is lost.

## Timing
- Byte accepted at edge N; the corresponding `wr_en`/`rd_en`/`alu_en` is high during cycle N+1 only.
- `rddata_vld`/`out_vld` at edge N: SEND at N+1, first `tx_d_vld` at N+2 if `fifo_full`=0 at N+1.
- Unstalled SEND pushes one byte per cycle; ALU_W=16 takes 2 consecutive cycles.
- A new opcode is accepted at the first edge after returning to IDLE.
- `rst` low at any edge aborts mid-frame or mid-SEND with no further strobes; all outputs 0 next cycle.

## Test plan
- AA, 0x05, 0x3C → one `wr_en` cycle with `address`=5, `wr_data`=0x3C; `busy` back to 0.
- BB, 0x02; `rddata`=0x7E valid 3 cycles after `rd_en` → single `tx_d_vld` with 0x7E.
- CC, 0x11, 0x22, 0x01; `alu_out`=0xBEEF → writes to addr 0 and addr 1, `alu_en` with fun 1, then bytes 0xEF, 0xBE; `fifo_full` held 4 cycles between them delays 0xBE, no loss.
- AA, 0x03, then silence TIMEOUT cycles → `err_pulse`, no `wr_en`; then EE → byte 0x01, then EE → byte 0x00.
- 0x55 in IDLE → `err_pulse`; 256 bad opcodes then EE → 0xFF (saturated).
- `rst` low during SEND of an 0xDD result after the first byte → second byte never sent, all outputs 0, IDLE.
